// File: rtl/rs_syndrome_engine.sv
// Reed-Solomon syndrome front end: Horner accumulation of NSYM syndromes with
// constant GF(2^m) multipliers, followed by a shadow bank and serial readout.
module rs_syndrome_engine #(
  parameter int              SYM_W     = 8,
  parameter logic [SYM_W:0]  PRIM_POLY = 'h11D,
  parameter int              N         = 204,
  parameter int              NSYM      = 16,
  parameter int              FCR       = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [SYM_W-1:0]     in_data,
  output logic                 out_valid,
  output logic [((NSYM > 1) ? $clog2(NSYM) : 1)-1:0] out_idx,
  output logic [SYM_W-1:0]     out_syn,
  output logic                 out_last,
  output logic                 frame_ok,
  output logic                 sof_err,
  output logic                 busy
);

  localparam int IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int CNT_W = $clog2(N + 1);
  localparam int ORDER = (1 << SYM_W) - 1;

  if (SYM_W < 3 || SYM_W > 12) begin : g_bad_sym_w
    $error("rs_syndrome_engine: SYM_W must be in 3..12");
  end
  if (!(NSYM < N && N <= ORDER)) begin : g_bad_n
    $error("rs_syndrome_engine: need NSYM < N <= 2^SYM_W-1");
  end

  function automatic logic [SYM_W-1:0] xtime(input logic [SYM_W-1:0] a);
    return {a[SYM_W-2:0], 1'b0} ^ (a[SYM_W-1] ? PRIM_POLY[SYM_W-1:0] : '0);
  endfunction

  function automatic logic [SYM_W-1:0] alpha_pow(input int e);
    logic [SYM_W-1:0] r;
    r = SYM_W'(1);
    for (int i = 0; i < (e % ORDER); i++) r = xtime(r);
    return r;
  endfunction

  // Shift-and-add with a constant c: collapses to a fixed XOR network.
  function automatic logic [SYM_W-1:0] gfmul_const(input logic [SYM_W-1:0] a,
                                                   input logic [SYM_W-1:0] c);
    logic [SYM_W-1:0] r;
    r = '0;
    for (int i = SYM_W - 1; i >= 0; i--) begin
      r = xtime(r);
      if (c[i]) r = r ^ a;
    end
    return r;
  endfunction

  typedef enum logic { IDLE, ACCUM } in_state_t;
  typedef enum logic { OUT_IDLE, OUT_SHIFT } out_state_t;

  in_state_t              state, state_next;
  out_state_t             out_state, out_state_next;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx, idx_next;
  logic [SYM_W-1:0]       acc    [NSYM];
  logic [SYM_W-1:0]       upd    [NSYM];
  logic [SYM_W-1:0]       shadow [NSYM];
  logic                   zero_flag;
  logic                   upd_nz;
  logic                   load, step, abort, done;

  for (genvar j = 0; j < NSYM; j++) begin : g_root
    localparam logic [SYM_W-1:0] ROOT = alpha_pow(FCR + j);
    assign upd[j] = gfmul_const(acc[j], ROOT) ^ in_data;
  end

  always_comb begin
    upd_nz = 1'b0;
    for (int j = 0; j < NSYM; j++) upd_nz = upd_nz | (|upd[j]);
  end

  // Input FSM: an in_sof always wins, even on what would be the last symbol.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    abort      = 1'b0;
    done       = 1'b0;
    if (in_valid) begin
      case (state)
        IDLE: begin
          if (in_sof) begin
            load       = 1'b1;
            state_next = ACCUM;
          end
        end
        ACCUM: begin
          if (in_sof) begin
            load  = 1'b1;
            abort = 1'b1;
          end else if (cnt == CNT_W'(N - 1)) begin
            done       = 1'b1;
            state_next = IDLE;
          end else begin
            step = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      sof_err   <= 1'b0;
      zero_flag <= 1'b0;
      for (int j = 0; j < NSYM; j++) begin
        acc[j]    <= '0;
        shadow[j] <= '0;
      end
    end else begin
      sof_err <= abort;
      if (load) begin
        cnt <= CNT_W'(1);
        for (int j = 0; j < NSYM; j++) acc[j] <= in_data;
      end else if (step) begin
        cnt <= cnt + CNT_W'(1);
        for (int j = 0; j < NSYM; j++) acc[j] <= upd[j];
      end else if (done) begin
        cnt       <= '0;
        zero_flag <= ~upd_nz;
        for (int j = 0; j < NSYM; j++) begin
          acc[j]    <= '0;
          shadow[j] <= upd[j];
        end
      end
    end
  end

  // Serializer: a fresh shadow load restarts the readout at index 0.
  always_comb begin
    out_state_next = out_state;
    idx_next       = idx;
    if (out_state == OUT_SHIFT) begin
      if (idx == IDX_W'(NSYM - 1)) begin
        out_state_next = OUT_IDLE;
        idx_next       = '0;
      end else begin
        idx_next = idx + IDX_W'(1);
      end
    end
    if (done) begin
      out_state_next = OUT_SHIFT;
      idx_next       = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_state <= OUT_IDLE;
      idx       <= '0;
    end else begin
      out_state <= out_state_next;
      idx       <= idx_next;
    end
  end

  assign busy      = (state == ACCUM);
  assign out_valid = (out_state == OUT_SHIFT);
  assign out_idx   = idx;
  assign out_syn   = out_valid ? shadow[idx] : '0;
  assign out_last  = out_valid && (idx == IDX_W'(NSYM - 1));
  assign frame_ok  = out_last && zero_flag;

endmodule
